bcd_seven_segment_scanner: RTL
==============================

// Module: bcd_seven_segment_scanner
// PURPOSE
//  Display stage directly downstream of the binary-to-BCD encoder. Captures a signed
//  6-digit BCD value (magnitude 0..131072 plus sign) and drives a time-multiplexed
//  7-position common-anode 7-segment display (6 digits + minus sign).
//  Applies leading-zero blanking, places the minus sign, and updates only on frame
//  boundaries so the display never tears.
// PARAMETERS
//  PRESCALE   1000  clk cycles each position stays lit (>=2)
//  NUM_POS    7     display positions scanned (fixed: 6 digits + 1 sign slot)
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  bcd_in       in   21  [20]=100k digit (0/1), [19:16]=10k ... [3:0]=units
//  neg          in   1   1 = value is negative
//  bcd_valid    in   1   1-cycle strobe: bcd_in/neg are valid this cycle
//  seg_n        out  7   segments {g,f,e,d,c,b,a}, active-low
//  an_n         out  7   position enables, active-low, an_n[0]=units position
//  frame_tick   out  1   1-cycle pulse when position index wraps 6->0
//  busy         out  1   1 while a captured value awaits the next frame boundary
// BEHAVIOUR
//  Reset (async): pending/shown regs=0 (shows "0"), pos=0, prescaler=0,
//   seg_n=7'h7F, an_n=7'h7F, frame_tick=0, busy=0.
//  Capture: bcd_valid=1 at a clk edge -> pending<={neg,bcd_in}, busy<=1 next cycle.
//   Multiple strobes before a boundary: last one wins.
//  Prescaler counts 0..PRESCALE-1; at PRESCALE-1 it wraps and pos advances
//   (0,1,..,6,0). On the 6->0 advance frame_tick=1 for one cycle; if busy, shown<=pending
//   and busy<=0 in that same cycle. A strobe in that same cycle goes to pending and
//   keeps busy=1 (new value wins; it is shown at the next boundary).
//  Outputs are registered: seg_n/an_n reflect pos one cycle after pos changes; exactly
//   one an_n bit is low at any time after the first post-reset cycle.
//  Digit rendering (position p, digit d_p from shown):
//   - msd = highest p in 0..5 with d_p!=0; if all zero, msd=0.
//   - p<=msd: decode d_p; p>msd and p<=5: blank, except minus.
//   - minus ("g" only, seg_n=7'h3F) at position msd+1 when neg=1 and value!=0;
//     negative zero renders as "0" with no sign.
//   - position 6 shows minus only when msd=5; otherwise blank.
//   - d_p>9 (illegal BCD) renders "E" (seg_n=7'h06); 100k digit uses {3'b0,bcd_in[20]}.
//  Blank = seg_n=7'h7F with an_n still asserted (keeps constant duty cycle).
//  Reset mid-frame: immediate return to reset values; pending value discarded.
// STRUCTURE
//  Shared package: segment constants (SEG_0..SEG_9, SEG_MINUS, SEG_E, SEG_BLANK),
//   NUM_POS, digit-width localparam.
//  Sub-module bcd_to_7seg: combinational 4-bit digit -> 7-bit active-low pattern,
//   including the "E" fallback. Top level holds prescaler, position counter, capture/
//   shadow registers, msd/sign logic and output registers.
// TESTING (bench uses PRESCALE=4)
//  1 Reset, no strobes -> one frame: an_n walks 7'h7E..7'h3F, seg_n=7'h40 ("0") at pos0,
//    7'h7F elsewhere; frame_tick every 28 cycles; busy=0.
//  2 Strobe bcd_in=21'h012345, neg=0 mid-frame -> busy=1 until next frame_tick; next
//    frame pos0..4 show 5,4,3,2,1 (7'h12,7'h19,7'h30,7'h24,7'h79); pos5,6 blank.
//  3 bcd_in=21'h000123, neg=1 -> pos0..2 show 3,2,1, pos3=7'h3F (minus), pos4..6 blank.
//  4 bcd_in=21'h131072 (bit20=1), neg=1 -> pos5 shows 1, pos6 shows minus;
//    bcd_in=0, neg=1 -> only pos0 "0", no minus.
//  5 Two strobes (21'h000001 then 21'h000009) in one frame -> next frame shows 9 only;
//    strobe coinciding with frame_tick -> displayed one frame later, busy stays 1.
//  6 Digit 4'hA at pos1 (bcd_in=21'h0000A0) -> pos1 seg_n=7'h06; assert rst mid-frame ->
//    seg_n/an_n=7'h7F immediately, busy=0, display returns to "0".

Source files
------------

// File: rtl/bcd_seven_segment_scanner_pkg.sv
// Shared constants for the BCD seven-segment scanner: segment glyphs
// (active-low {g,f,e,d,c,b,a}), display geometry and digit extraction.
package bcd_seven_segment_scanner_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 6;
    localparam int unsigned NUM_POS    = 7;
    localparam int unsigned POS_W      = 3;
    localparam int unsigned BCD_W      = 21;
    localparam int unsigned SEG_W      = 7;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
    localparam logic [SEG_W-1:0] SEG_MINUS = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    // The 100k digit is a single bit, widened to a full BCD digit.
    function automatic logic [DIGIT_W-1:0] digit_at(input logic [BCD_W-1:0] bcd,
                                                    input int unsigned p);
        logic [DIGIT_W-1:0] d;
        if (p < NUM_DIGITS - 1)
            d = bcd[DIGIT_W*p +: DIGIT_W];
        else
            d = {3'b000, bcd[BCD_W-1]};
        return d;
    endfunction

endpackage

// File: rtl/bcd_seven_segment_scanner_bcd_to_7seg.sv
// Combinational BCD digit to active-low seven-segment pattern;
// codes above 9 render as "E".
module bcd_to_7seg
    import bcd_seven_segment_scanner_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    output logic [SEG_W-1:0]   seg_n
);

    always_comb begin
        seg_n = SEG_E;
        case (digit)
            4'd0: seg_n = SEG_0;
            4'd1: seg_n = SEG_1;
            4'd2: seg_n = SEG_2;
            4'd3: seg_n = SEG_3;
            4'd4: seg_n = SEG_4;
            4'd5: seg_n = SEG_5;
            4'd6: seg_n = SEG_6;
            4'd7: seg_n = SEG_7;
            4'd8: seg_n = SEG_8;
            4'd9: seg_n = SEG_9;
            default: seg_n = SEG_E;
        endcase
    end

endmodule

// File: rtl/bcd_seven_segment_scanner.sv
// Time-multiplexed 7-position display driver with leading-zero blanking,
// minus-sign placement and frame-synchronous value updates.
module bcd_seven_segment_scanner
    import bcd_seven_segment_scanner_pkg::*;
#(
    parameter int unsigned PRESCALE = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BCD_W-1:0]   bcd_in,
    input  logic               neg,
    input  logic               bcd_valid,
    output logic [SEG_W-1:0]   seg_n,
    output logic [NUM_POS-1:0] an_n,
    output logic               frame_tick,
    output logic               busy
);

    localparam int unsigned     PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(NUM_POS - 1);

    logic [PS_W-1:0]    presc;
    logic [POS_W-1:0]   pos;
    logic [BCD_W-1:0]   pend_bcd;
    logic               pend_neg;
    logic [BCD_W-1:0]   shown_bcd;
    logic               shown_neg;

    logic [DIGIT_W-1:0] digits [NUM_DIGITS];
    logic [POS_W-1:0]   msd;
    logic               nonzero;
    logic [DIGIT_W-1:0] cur_digit;
    logic [SEG_W-1:0]   dec_seg;
    logic [SEG_W-1:0]   next_seg;
    logic               wrap;
    logic               frame_end;

    assign wrap      = (presc == PS_LAST);
    assign frame_end = wrap && (pos == POS_LAST);
    assign nonzero   = |shown_bcd;

    always_comb begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            digits[i] = digit_at(shown_bcd, i);
    end

    // Most significant non-zero digit; an all-zero value keeps the units digit.
    always_comb begin
        msd = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (digits[i] != '0)
                msd = POS_W'(i);
    end

    always_comb begin
        cur_digit = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++)
            if (pos == POS_W'(i))
                cur_digit = digits[i];
    end

    bcd_to_7seg u_dec (
        .digit (cur_digit),
        .seg_n (dec_seg)
    );

    // Position 6 is never <= msd, so it only ever shows the sign or blank.
    always_comb begin
        next_seg = SEG_BLANK;
        if (pos <= msd)
            next_seg = dec_seg;
        else if (shown_neg && nonzero && (pos == msd + POS_W'(1)))
            next_seg = SEG_MINUS;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc      <= '0;
            pos        <= '0;
            pend_bcd   <= '0;
            pend_neg   <= 1'b0;
            shown_bcd  <= '0;
            shown_neg  <= 1'b0;
            busy       <= 1'b0;
            frame_tick <= 1'b0;
            seg_n      <= SEG_BLANK;
            an_n       <= '1;
        end else begin
            presc      <= wrap ? '0 : presc + PS_W'(1);
            frame_tick <= frame_end;
            if (wrap)
                pos <= (pos == POS_LAST) ? '0 : pos + POS_W'(1);

            if (frame_end && busy) begin
                shown_bcd <= pend_bcd;
                shown_neg <= pend_neg;
            end

            // A strobe on the boundary edge lands in pending and keeps busy set.
            if (bcd_valid) begin
                pend_bcd <= bcd_in;
                pend_neg <= neg;
                busy     <= 1'b1;
            end else if (frame_end) begin
                busy     <= 1'b0;
            end

            seg_n <= next_seg;
            an_n  <= ~(NUM_POS'(1) << pos);
        end
    end

endmodule
